// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches 32-bit instructions over a
// req/ready handshake and hands them to decode through a one-entry slot
// (if_valid / if_inst / if_pc).
//
// Handshake: imem_req is raised with imem_addr. Both stay stable until a cycle
// in which imem_ready=1, and that cycle completes the request. Completion may
// occur in the same cycle the request is raised. imem_ready is ignored
// whenever imem_req=0. A redirect never withdraws an outstanding request. The
// request runs to completion in DROP and its data is discarded there.
module inst_fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  input  logic            imem_ready,
  input  logic            stall,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_valid,
  output logic [31:0]     if_inst,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_pc_plus4,
  output logic [1:0]      dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } state_t;

  localparam logic [XLEN-1:0] PC_STEP   = XLEN'(4);
  localparam logic [XLEN-1:0] ALIGN_MSK = ~XLEN'(3);
  localparam logic [31:0]     NOP_INST  = 32'h0000_0013;

  state_t          r_state;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_req_addr;
  logic            r_if_valid;
  logic [31:0]     r_if_inst;
  logic [XLEN-1:0] r_if_pc;

  logic            w_can_issue;
  logic            w_consume;
  logic            w_req;
  logic [XLEN-1:0] w_addr;
  logic            w_capture;
  logic [XLEN-1:0] w_redirect_pc;

  assign w_redirect_pc = redirect_pc & ALIGN_MSK;

  // Request generation: IDLE issues from pc when the slot can accept a
  // response, WAIT/DROP keep presenting the outstanding address.
  always_comb begin
    w_can_issue = !r_if_valid || !stall;
    w_consume   = r_if_valid && !stall;
    w_req       = 1'b0;
    w_addr      = r_pc;
    case (r_state)
      S_IDLE: begin
        w_req  = w_can_issue && !redirect;
        w_addr = r_pc;
      end
      S_WAIT, S_DROP: begin
        w_req  = 1'b1;
        w_addr = r_req_addr;
      end
      default: begin
        w_req  = 1'b0;
        w_addr = r_pc;
      end
    endcase
    // Data is kept only for a live (non-dropped) request with no redirect this cycle
    w_capture = w_req && imem_ready && !redirect && (r_state != S_DROP);
  end

  // Request is withdrawn immediately while reset is held
  assign imem_req    = w_req && rst_n;
  assign imem_addr   = w_addr;
  assign if_valid    = r_if_valid;
  assign if_inst     = r_if_inst;
  assign if_pc       = r_if_pc;
  assign if_pc_plus4 = r_if_pc + PC_STEP;
  assign dbg_state   = r_state;

  // Fetch FSM, PC and decode slot; redirect outranks stall and a same-cycle response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_pc       <= RESET_PC;
      r_req_addr <= RESET_PC;
      r_if_valid <= 1'b0;
      r_if_inst  <= NOP_INST;
      r_if_pc    <= RESET_PC;
    end else if (redirect) begin
      r_pc       <= w_redirect_pc;
      r_if_valid <= 1'b0;
      case (r_state)
        S_IDLE:         r_state <= S_IDLE;
        S_WAIT, S_DROP: r_state <= imem_ready ? S_IDLE : S_DROP;
        default:        r_state <= S_IDLE;
      endcase
    end else begin
      if (w_capture) begin
        r_if_inst  <= imem_rdata;
        r_if_pc    <= w_addr;
        r_if_valid <= 1'b1;
        r_pc       <= r_pc + PC_STEP;
      end else if (w_consume) begin
        r_if_valid <= 1'b0;
      end
      case (r_state)
        S_IDLE: begin
          if (w_req && !imem_ready) begin
            r_req_addr <= r_pc;
            r_state    <= S_WAIT;
          end
        end
        S_WAIT, S_DROP: begin
          if (imem_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: a directed cycle table, a hand-written
// wrap/reset-in-flight sequence, and a randomized run against a
// program-order reference model with a variable-latency memory.
module tb_inst_fetch_unit;

  localparam int          XLEN     = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;
  logic [1:0]  dbg_state;

  int n_checks;
  int n_fail;

  inst_fetch_unit #(.XLEN(XLEN), .RESET_PC(RESET_PC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .imem_ready  (imem_ready),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .if_valid    (if_valid),
    .if_inst     (if_inst),
    .if_pc       (if_pc),
    .if_pc_plus4 (if_pc_plus4),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog expired");
  end

  // Memory contents: every word is tagged with its own address
  function automatic logic [31:0] tag(input logic [31:0] a);
    return (a * 32'd2654435761) ^ 32'h0000_0013;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Hold reset a few cycles, check reset values, release just after a rising edge
  task automatic do_reset();
    rst_n       = 1'b0;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    imem_ready  = 1'b0;
    imem_rdata  = '0;
    repeat (3) @(negedge clk);
    check("rst_req",   {31'd0, imem_req}, 32'd0);
    check("rst_valid", {31'd0, if_valid}, 32'd0);
    check("rst_inst",  if_inst, 32'h0000_0013);
    check("rst_pc",    if_pc, RESET_PC);
    check("rst_addr",  imem_addr, RESET_PC);
    check("rst_state", {30'd0, dbg_state}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // ---------------- driver ----------------
  // Drive one cycle: inputs at the falling edge, memory data 1ns later,
  // outputs sampled 2ns after the falling edge (well before the rising edge).
  task automatic apply(input logic s, input logic r, input logic [31:0] rpc, input logic rdy);
    @(negedge clk);
    stall       = s;
    redirect    = r;
    redirect_pc = rpc;
    imem_ready  = rdy;
    #1;
    imem_rdata  = tag(imem_addr);
    #1;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic        stall;
    logic        redir;
    logic [31:0] rpc;
    logic        ready;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic s, input logic r, input logic [31:0] rpc, input logic rdy,
                         input logic ereq, input logic [31:0] eaddr, input logic ev,
                         input logic [31:0] epc);
    vec_t v;
    v.stall = s; v.redir = r; v.rpc = rpc; v.ready = rdy;
    v.e_req = ereq; v.e_addr = eaddr; v.e_valid = ev; v.e_pc = epc;
    vecs.push_back(v);
  endtask

  // ---------------- random-phase model state ----------------
  logic [31:0] fetch_ptr;
  logic [31:0] exp_pc;
  logic        dropping;
  logic        mem_busy;
  int          mem_cnt;
  logic        prev_pending;
  logic [31:0] prev_addr;
  logic        prev_hold;
  logic [31:0] prev_pc;
  logic [31:0] prev_inst;
  logic        prev_redirect;
  int          n_consumed;

  initial begin
    n_checks = 0;
    n_fail   = 0;

    //       stall redir rpc           rdy | req addr          valid if_pc
    // zero-wait streaming
    add_vec(0, 0, 32'h0,         1,   1, 32'h0000_0000, 0, 32'h0000_0000);
    add_vec(0, 0, 32'h0,         1,   1, 32'h0000_0004, 1, 32'h0000_0000);
    // 3 extra wait cycles at address 8
    add_vec(0, 0, 32'h0,         0,   1, 32'h0000_0008, 1, 32'h0000_0004);
    add_vec(0, 0, 32'h0,         0,   1, 32'h0000_0008, 0, 32'h0000_0004);
    add_vec(0, 0, 32'h0,         0,   1, 32'h0000_0008, 0, 32'h0000_0004);
    add_vec(0, 0, 32'h0,         1,   1, 32'h0000_0008, 0, 32'h0000_0004);
    add_vec(0, 0, 32'h0,         1,   1, 32'h0000_000C, 1, 32'h0000_0008);
    // 4-cycle stall with a full slot; stray ready must be ignored
    add_vec(1, 0, 32'h0,         1,   0, 32'h0000_0010, 1, 32'h0000_000C);
    add_vec(1, 0, 32'h0,         1,   0, 32'h0000_0010, 1, 32'h0000_000C);
    add_vec(1, 0, 32'h0,         1,   0, 32'h0000_0010, 1, 32'h0000_000C);
    add_vec(1, 0, 32'h0,         1,   0, 32'h0000_0010, 1, 32'h0000_000C);
    add_vec(0, 0, 32'h0,         1,   1, 32'h0000_0010, 1, 32'h0000_000C);
    // redirect to 0x100 while waiting on 0x14: outstanding request drained
    add_vec(0, 0, 32'h0,         0,   1, 32'h0000_0014, 1, 32'h0000_0010);
    add_vec(0, 1, 32'h100,       0,   1, 32'h0000_0014, 0, 32'h0000_0010);
    add_vec(0, 0, 32'h0,         0,   1, 32'h0000_0014, 0, 32'h0000_0010);
    add_vec(0, 0, 32'h0,         1,   1, 32'h0000_0014, 0, 32'h0000_0010);
    add_vec(0, 0, 32'h0,         1,   1, 32'h0000_0100, 0, 32'h0000_0010);
    add_vec(0, 0, 32'h0,         1,   1, 32'h0000_0104, 1, 32'h0000_0100);
    // redirect 0x203 coincident with ready and stall while waiting
    add_vec(0, 0, 32'h0,         0,   1, 32'h0000_0108, 1, 32'h0000_0104);
    add_vec(1, 1, 32'h203,       1,   1, 32'h0000_0108, 0, 32'h0000_0104);
    add_vec(0, 0, 32'h0,         1,   1, 32'h0000_0200, 0, 32'h0000_0104);
    add_vec(0, 0, 32'h0,         1,   1, 32'h0000_0204, 1, 32'h0000_0200);
    // redirect in idle with a stalled full slot: flush, no request that cycle
    add_vec(1, 1, 32'h40,        1,   0, 32'h0000_0208, 1, 32'h0000_0204);
    add_vec(1, 0, 32'h0,         1,   1, 32'h0000_0040, 0, 32'h0000_0204);
    add_vec(0, 0, 32'h0,         1,   1, 32'h0000_0044, 1, 32'h0000_0040);
    // two redirects while draining: the last one wins
    add_vec(0, 0, 32'h0,         0,   1, 32'h0000_0048, 1, 32'h0000_0044);
    add_vec(0, 1, 32'h300,       0,   1, 32'h0000_0048, 0, 32'h0000_0044);
    add_vec(0, 1, 32'h400,       0,   1, 32'h0000_0048, 0, 32'h0000_0044);
    add_vec(0, 0, 32'h0,         1,   1, 32'h0000_0048, 0, 32'h0000_0044);
    add_vec(0, 0, 32'h0,         1,   1, 32'h0000_0400, 0, 32'h0000_0044);
    add_vec(0, 0, 32'h0,         1,   1, 32'h0000_0404, 1, 32'h0000_0400);

    do_reset();
    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i].stall, vecs[i].redir, vecs[i].rpc, vecs[i].ready);
      check($sformatf("v%0d_req", i),   {31'd0, imem_req}, {31'd0, vecs[i].e_req});
      check($sformatf("v%0d_addr", i),  imem_addr, vecs[i].e_addr);
      check($sformatf("v%0d_valid", i), {31'd0, if_valid}, {31'd0, vecs[i].e_valid});
      check($sformatf("v%0d_pc", i),    if_pc, vecs[i].e_pc);
      check($sformatf("v%0d_pc4", i),   if_pc_plus4, vecs[i].e_pc + 32'd4);
      if (vecs[i].e_valid) check($sformatf("v%0d_inst", i), if_inst, tag(vecs[i].e_pc));
    end

    // ---- PC wrap at the top of the address space, then reset mid-wait ----
    do_reset();
    apply(0, 1, 32'hFFFF_FFFE, 0);
    check("wrap_redir_req", {31'd0, imem_req}, 32'd0);
    apply(0, 0, 32'h0, 1);
    check("wrap_req_top",  {31'd0, imem_req}, 32'd1);
    check("wrap_addr_top", imem_addr, 32'hFFFF_FFFC);
    apply(0, 0, 32'h0, 0);
    check("wrap_addr_zero", imem_addr, 32'h0000_0000);
    check("wrap_valid",     {31'd0, if_valid}, 32'd1);
    check("wrap_pc",        if_pc, 32'hFFFF_FFFC);
    check("wrap_pc4",       if_pc_plus4, 32'h0000_0000);
    check("wrap_inst",      if_inst, tag(32'hFFFF_FFFC));
    apply(0, 0, 32'h0, 0);
    check("wait_req",   {31'd0, imem_req}, 32'd1);
    check("wait_addr",  imem_addr, 32'h0000_0000);
    check("wait_valid", {31'd0, if_valid}, 32'd0);
    #1 rst_n = 1'b0;
    #1;
    check("arst_req",   {31'd0, imem_req}, 32'd0);
    check("arst_valid", {31'd0, if_valid}, 32'd0);
    check("arst_pc",    if_pc, RESET_PC);
    check("arst_inst",  if_inst, 32'h0000_0013);
    check("arst_addr",  imem_addr, RESET_PC);

    // ---- randomized run against the program-order model ----
    do_reset();
    fetch_ptr     = RESET_PC;
    exp_pc        = RESET_PC;
    dropping      = 1'b0;
    mem_busy      = 1'b0;
    mem_cnt       = 0;
    prev_pending  = 1'b0;
    prev_addr     = '0;
    prev_hold     = 1'b0;
    prev_pc       = '0;
    prev_inst     = '0;
    prev_redirect = 1'b0;
    n_consumed    = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      stall    = ($urandom_range(0, 9) < 3);
      redirect = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 3) == 0) redirect_pc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      else                           redirect_pc = $urandom;
      #1;
      if (imem_req) begin
        if (!mem_busy) begin
          mem_busy = 1'b1;
          mem_cnt  = $urandom_range(0, 3);
        end
        imem_ready = (mem_cnt == 0);
      end else begin
        imem_ready = 1'($urandom_range(0, 1));
      end
      imem_rdata = tag(imem_addr);
      #1;

      check("r_pc4", if_pc_plus4, if_pc + 32'd4);
      if (imem_req) check("r_align", {30'd0, imem_addr[1:0]}, 32'd0);
      if (prev_pending) begin
        check("r_hold_req",  {31'd0, imem_req}, 32'd1);
        check("r_hold_addr", imem_addr, prev_addr);
      end else if (imem_req) begin
        check("r_issue_addr", imem_addr, fetch_ptr);
      end
      if (prev_hold) begin
        check("r_stall_valid", {31'd0, if_valid}, 32'd1);
        check("r_stall_pc",    if_pc, prev_pc);
        check("r_stall_inst",  if_inst, prev_inst);
      end
      if (prev_redirect) check("r_flush", {31'd0, if_valid}, 32'd0);
      if (if_valid && !stall && !redirect) begin
        check("r_order_pc", if_pc, exp_pc);
        check("r_inst",     if_inst, tag(if_pc));
        exp_pc = exp_pc + 32'd4;
        n_consumed++;
      end

      // Effect of the coming clock edge on the program-order model
      if (redirect) begin
        fetch_ptr = redirect_pc & ~32'd3;
        exp_pc    = redirect_pc & ~32'd3;
        dropping  = imem_req && !imem_ready;
      end else if (imem_req && imem_ready) begin
        if (dropping) dropping = 1'b0;
        else          fetch_ptr = imem_addr + 32'd4;
      end
      if (imem_req) begin
        if (imem_ready) mem_busy = 1'b0;
        else            mem_cnt--;
      end
      prev_pending  = imem_req && !imem_ready;
      prev_addr     = imem_addr;
      prev_hold     = if_valid && stall && !redirect;
      prev_pc       = if_pc;
      prev_inst     = if_inst;
      prev_redirect = redirect;
    end
    check("r_progress", {31'd0, (n_consumed >= 200)}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
